shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_shift_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// shift_sched -- pairs per-packet shift commands with the head slice stream.
//
// A small command FIFO holds {head shift, meta shift} pairs produced by the
// parse lookup. Each packet start on the slice stream pops one command. The
// shift amounts are latched and held for the whole packet. Slice tags are
// forwarded to the shifter one cycle after acceptance.
//
// Ports
//   i_clk, i_rst                  clock; asynchronous active-high reset
//   i_cmd_valid/_headShift/_metaShift, o_cmd_ready
//                                 command push interface (FIFO not full)
//   i_slice_valid/_start/_tail, o_slice_ready
//                                 upstream head slice stream tags
//   o_slice_valid/_start/_tail    registered tags toward the shifter
//   o_headShift, o_metaShift      shift amounts, valid with o_slice_start
//   o_err                         one-cycle protocol error pulse
//   o_pktCnt                      packets launched (commands popped), wraps
module shift_sched #(
  parameter int HEAD_SHIFT_W = 4,
  parameter int META_SHIFT_W = 3,
  parameter int CMD_DEPTH    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  input  logic [HEAD_SHIFT_W-1:0] i_cmd_headShift,
  input  logic [META_SHIFT_W-1:0] i_cmd_metaShift,
  output logic                    o_cmd_ready,
  input  logic                    i_slice_valid,
  input  logic                    i_slice_start,
  input  logic                    i_slice_tail,
  output logic                    o_slice_ready,
  output logic                    o_slice_valid,
  output logic                    o_slice_start,
  output logic                    o_slice_tail,
  output logic [HEAD_SHIFT_W-1:0] o_headShift,
  output logic [META_SHIFT_W-1:0] o_metaShift,
  output logic                    o_err,
  output logic [15:0]             o_pktCnt
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = HEAD_SHIFT_W + META_SHIFT_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_CMD = 2'd1,
    S_PASS     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [CMD_W-1:0] mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] rd_cmd;

  // Full/empty come from the registered occupancy only, so a push offered
  // while full is refused even if a pop happens in the same cycle, and a
  // freshly pushed command is not visible to the pop side until next cycle.
  assign fifo_full   = (count_q == CNT_W'(CMD_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push        = i_cmd_valid & ~fifo_full;
  assign o_cmd_ready = ~fifo_full;
  assign rd_cmd      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_cmd_headShift, i_cmd_metaShift};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Packet state machine
  // ---------------------------------------------------------------------
  state_t state_q, state_d;
  state_t start_target;
  logic   slice_start;
  logic   slice_ready;
  logic   fwd;
  logic   drop_err;
  logic   pkt_err;

  assign slice_start = i_slice_valid & i_slice_start;

  // Where a packet start leads: stall if no command yet, otherwise launch
  // (a single-slice packet goes straight back to IDLE).
  assign start_target = fifo_empty ? S_WAIT_CMD :
                        (i_slice_tail ? S_IDLE : S_PASS);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (slice_start) state_d = start_target;
      end
      S_WAIT_CMD: begin
        if (!fifo_empty) state_d = slice_start ? start_target : S_IDLE;
      end
      S_PASS: begin
        if (slice_start) begin
          state_d = start_target;
        end else if (i_slice_valid && i_slice_tail) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slice_ready = 1'b1;
    fwd         = 1'b0;
    drop_err    = 1'b0;
    pkt_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (slice_start) begin
          slice_ready = ~fifo_empty;
          fwd         = ~fifo_empty;
        end else if (i_slice_valid) begin
          drop_err = 1'b1;  // body slice with no packet open: swallow it
        end
      end
      S_WAIT_CMD: begin
        if (fifo_empty) begin
          slice_ready = 1'b0;
        end else if (slice_start) begin
          fwd = 1'b1;
        end else if (i_slice_valid) begin
          drop_err = 1'b1;
        end
      end
      S_PASS: begin
        if (slice_start) begin
          // Unexpected start: flag it and restart on the new packet.
          pkt_err     = 1'b1;
          slice_ready = ~fifo_empty;
          fwd         = ~fifo_empty;
        end else begin
          fwd = i_slice_valid;
        end
      end
      default: slice_ready = 1'b1;
    endcase
  end

  assign o_slice_ready = slice_ready;
  assign pop           = fwd & i_slice_start;

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic                    slice_valid_q, slice_valid_d;
  logic                    slice_start_q, slice_start_d;
  logic                    slice_tail_q, slice_tail_d;
  logic                    err_q, err_d;
  logic [HEAD_SHIFT_W-1:0] head_q, head_d;
  logic [META_SHIFT_W-1:0] meta_q, meta_d;
  logic [15:0]             pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    slice_valid_d = fwd;
    slice_start_d = fwd & i_slice_start;
    slice_tail_d  = fwd & i_slice_tail;
    err_d         = drop_err | pkt_err;
    head_d        = head_q;
    meta_d        = meta_q;
    pkt_cnt_d     = pkt_cnt_q;
    if (pop) begin
      head_d    = rd_cmd[CMD_W-1:META_SHIFT_W];
      meta_d    = rd_cmd[META_SHIFT_W-1:0];
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slice_valid_q <= 1'b0;
      slice_start_q <= 1'b0;
      slice_tail_q  <= 1'b0;
      err_q         <= 1'b0;
      head_q        <= '0;
      meta_q        <= '0;
      pkt_cnt_q     <= '0;
    end else begin
      slice_valid_q <= slice_valid_d;
      slice_start_q <= slice_start_d;
      slice_tail_q  <= slice_tail_d;
      err_q         <= err_d;
      head_q        <= head_d;
      meta_q        <= meta_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  assign o_slice_valid = slice_valid_q;
  assign o_slice_start = slice_start_q;
  assign o_slice_tail  = slice_tail_q;
  assign o_err         = err_q;
  assign o_headShift   = head_q;
  assign o_metaShift   = meta_q;
  assign o_pktCnt      = pkt_cnt_q;

endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched -- self-checking bench for shift_sched.
// Directed scenarios followed by a randomized run. Expected behaviour comes
// from a packet-level reference model: a queue of pending commands plus
// "inside a packet" and "waiting for a command" flags.
module tb_shift_sched;
  localparam int HW    = 4;
  localparam int MW    = 3;
  localparam int DEPTH = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic [HW-1:0] i_cmd_headShift;
  logic [MW-1:0] i_cmd_metaShift;
  logic          o_cmd_ready;
  logic          i_slice_valid, i_slice_start, i_slice_tail;
  logic          o_slice_ready;
  logic          o_slice_valid, o_slice_start, o_slice_tail;
  logic [HW-1:0] o_headShift;
  logic [MW-1:0] o_metaShift;
  logic          o_err;
  logic [15:0]   o_pktCnt;

  always #5 i_clk = ~i_clk;

  shift_sched #(.HEAD_SHIFT_W(HW), .META_SHIFT_W(MW), .CMD_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_headShift(i_cmd_headShift),
    .i_cmd_metaShift(i_cmd_metaShift), .o_cmd_ready(o_cmd_ready),
    .i_slice_valid(i_slice_valid), .i_slice_start(i_slice_start),
    .i_slice_tail(i_slice_tail), .o_slice_ready(o_slice_ready),
    .o_slice_valid(o_slice_valid), .o_slice_start(o_slice_start),
    .o_slice_tail(o_slice_tail), .o_headShift(o_headShift),
    .o_metaShift(o_metaShift), .o_err(o_err), .o_pktCnt(o_pktCnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [HW-1:0] h;
    logic [MW-1:0] m;
  } cmd_t;

  cmd_t          cmd_q[$];
  bit            in_pkt;
  bit            stalled;
  logic [HW-1:0] m_head;
  logic [MW-1:0] m_meta;
  logic [15:0]   m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    cmd_q.delete();
    in_pkt  = 0;
    stalled = 0;
    m_head  = '0;
    m_meta  = '0;
    m_cnt   = '0;
  endtask

  // One clock cycle: drive inputs, check the combinational readies, then
  // check everything the edge should have produced.
  task automatic step(input bit cv, input logic [HW-1:0] ch, input logic [MW-1:0] cm,
                      input bit sv, input bit ss, input bit st);
    bit avail, full, e_ready, e_fwd, e_err, e_start, e_tail;
    cmd_t c;
    @(negedge i_clk);
    i_cmd_valid     = cv;
    i_cmd_headShift = ch;
    i_cmd_metaShift = cm;
    i_slice_valid   = sv;
    i_slice_start   = ss;
    i_slice_tail    = st;
    #1;
    avail   = (cmd_q.size() > 0);
    full    = (cmd_q.size() == DEPTH);
    e_ready = 1;
    e_fwd   = 0;
    e_err   = 0;
    if (avail) stalled = 0;
    if (stalled) begin
      e_ready = 0;                      // waiting for a command: hold everything
    end else if (sv && ss) begin
      e_err = in_pkt;                   // start inside an open packet
      if (avail) begin
        c = cmd_q.pop_front();
        m_head = c.h;
        m_meta = c.m;
        m_cnt  = m_cnt + 16'd1;
        e_fwd  = 1;
        in_pkt = !st;
      end else begin
        e_ready = 0;
        in_pkt  = 0;
        stalled = 1;
      end
    end else if (sv) begin
      if (in_pkt) begin
        e_fwd = 1;
        if (st) in_pkt = 0;
      end else begin
        e_err = 1;                      // body slice outside a packet
      end
    end
    e_start = e_fwd && ss;
    e_tail  = e_fwd && st;
    chk("slice_ready", 32'(o_slice_ready), 32'(e_ready));
    chk("cmd_ready", 32'(o_cmd_ready), 32'(!full));
    if (cv && !full) begin
      c.h = ch;
      c.m = cm;
      cmd_q.push_back(c);
    end
    @(posedge i_clk);
    #1;
    chk("slice_valid", 32'(o_slice_valid), 32'(e_fwd));
    chk("slice_start", 32'(o_slice_start), 32'(e_start));
    chk("slice_tail", 32'(o_slice_tail), 32'(e_tail));
    chk("err", 32'(o_err), 32'(e_err));
    if (e_fwd) begin
      chk("headShift", 32'(o_headShift), 32'(m_head));
      chk("metaShift", 32'(o_metaShift), 32'(m_meta));
    end
    chk("pktCnt", 32'(o_pktCnt), 32'(m_cnt));
    $display("t=%0t cmd v=%0b %0d/%0d slice v=%0b s=%0b t=%0b -> out v=%0b s=%0b t=%0b hs=%0d ms=%0d err=%0b cnt=%0d q=%0d",
             $time, cv, ch, cm, sv, ss, st, o_slice_valid, o_slice_start, o_slice_tail,
             o_headShift, o_metaShift, o_err, o_pktCnt, cmd_q.size());
  endtask

  task automatic idle_inputs();
    i_cmd_valid     = 0;
    i_cmd_headShift = '0;
    i_cmd_metaShift = '0;
    i_slice_valid   = 0;
    i_slice_start   = 0;
    i_slice_tail    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_slice_valid), 32'd0);
    chk({tag, "_start"}, 32'(o_slice_start), 32'd0);
    chk({tag, "_tail"}, 32'(o_slice_tail), 32'd0);
    chk({tag, "_head"}, 32'(o_headShift), 32'd0);
    chk({tag, "_meta"}, 32'(o_metaShift), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_cnt"}, 32'(o_pktCnt), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic async_reset(input string tag);
    @(negedge i_clk);
    #2;
    idle_inputs();
    i_rst = 1;
    #1;
    check_reset_outputs(tag);
    $display("t=%0t async reset %s", $time, tag);
    @(negedge i_clk);
    i_rst = 0;
    model_clear();
  endtask

  initial begin
    i_rst = 1;
    idle_inputs();
    model_clear();
    #3;
    check_reset_outputs("por");
    @(negedge i_clk);
    i_rst = 0;

    // Body slice with no packet open: dropped, error pulse.
    step(0, 0, 0, 1, 0, 0);

    // Basic 3-slice packet with cmd (3,2).
    step(1, 3, 2, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("pkt_after_basic", 32'(o_pktCnt), 32'd1);

    // Start with empty FIFO; command arrives 5 cycles later.
    repeat (5) step(0, 0, 0, 1, 1, 0);
    step(1, 5, 4, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);

    // Fill the FIFO, then push against full, including during a pop.
    step(1, 1, 1, 0, 0, 0);
    step(1, 2, 2, 0, 0, 0);
    step(1, 3, 3, 0, 0, 0);
    step(1, 4, 4, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0);
    step(1, 9, 1, 1, 1, 1);
    step(1, 9, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 1, 1);

    // Start while a packet is open.
    step(1, 6, 3, 0, 0, 0);
    step(1, 8, 6, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);

    // Back-to-back single-slice packets.
    step(1, 1, 0, 0, 0, 0);
    step(1, 7, 5, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);

    // Reset inside a packet with commands still queued.
    step(1, 2, 1, 0, 0, 0);
    step(1, 3, 2, 0, 0, 0);
    step(1, 4, 3, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    async_reset("midpkt");
    step(0, 0, 0, 1, 0, 1);   // body slice after reset must be dropped
    step(0, 0, 0, 1, 1, 0);   // queue was discarded: start must stall

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, HW'($urandom), MW'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    async_reset("end");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
